// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-requester GPIO access arbiter.
// Optional round-robin tie-breaking is enabled by defining GPIO_ARB_ROUND_ROBIN_EN.
package gpio_arb_pkg;

  localparam int NUM_REQ = 2;

  // Register offsets of the GPIO port as seen through gpio_addr.
  localparam logic [1:0] GPIO_REG_OUT = 2'h0;
  localparam logic [1:0] GPIO_REG_IN  = 2'h1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/gpio_arb_grant.sv
// Combinational grant selection between the two requesters.
// With GPIO_ARB_ROUND_ROBIN_EN a tie goes to the requester not granted last; otherwise requester 0 wins.
module gpio_arb_grant
  import gpio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid_i,
`ifdef GPIO_ARB_ROUND_ROBIN_EN
  input  logic               ptr_i,
`endif
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
    // ptr_i is the index granted last, so a tie favours the other one.
    if (req_valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_valid_i;
    end
`else
    if (req_valid_i[0]) begin
      grant_o = 2'b01;
    end else if (req_valid_i[1]) begin
      grant_o = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/gpio_access_arbiter.sv
// Arbitrates two requesters onto a single GPIO port: IDLE -> SELECT (SEL_CYCLES) -> CAPTURE -> RESP.
// Define GPIO_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module gpio_access_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int SEL_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [63:0]          req_addr,
  input  logic [63:0]          req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_rvalid,
  output logic [31:0]          req_rdata,
  output logic [31:0]          gpio_addr,
  output logic [31:0]          gpio_wdata,
  output logic                 gpio_select,
  input  logic [31:0]          gpio_rdata,
  output logic [1:0]           dbg_state_o
);

  localparam logic [3:0] SEL_LOAD = 4'(SEL_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         we_q, we_d;
  logic         owner_q, owner_d;
  logic [NUM_REQ-1:0] grant;
  logic         accept;
  logic         acc_idx;

`ifdef GPIO_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
`endif

  gpio_arb_grant u_grant (
    .req_valid_i (req_valid),
`ifdef GPIO_ARB_ROUND_ROBIN_EN
    .ptr_i       (ptr_q),
`endif
    .grant_o     (grant)
  );

  // Handshake: a request is taken on a rising edge where req_valid[i] & req_ready[i];
  // ready is only offered in IDLE, and a requester may withdraw valid at any time before that.
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign acc_idx   = grant[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    owner_d = owner_q;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SELECT;
          cnt_d   = SEL_LOAD;
          addr_d  = acc_idx ? req_addr[63:32]  : req_addr[31:0];
          wdata_d = acc_idx ? req_wdata[63:32] : req_wdata[31:0];
          we_d    = req_we[acc_idx];
          owner_d = acc_idx;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
          ptr_d   = acc_idx;
`endif
        end
      end
      ST_SELECT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        rdata_d = we_q ? 32'h0 : gpio_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      owner_q <= owner_d;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gpio_select = (state_q == ST_SELECT);
  assign gpio_addr   = addr_q;
  assign gpio_wdata  = wdata_q;
  assign req_rvalid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign req_rdata   = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed bench for gpio_access_arbiter: one instance with SEL_CYCLES=1, one with SEL_CYCLES=3.
module tb_gpio_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_we, req_ready, req_rvalid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] req_rdata, gpio_addr, gpio_wdata, gpio_rdata;
  logic        gpio_select;
  logic [1:0]  dbg_state;

  logic [1:0]  req_valid3, req_we3, req_ready3, req_rvalid3;
  logic [63:0] req_addr3, req_wdata3;
  logic [31:0] req_rdata3, gpio_addr3, gpio_wdata3, gpio_rdata3;
  logic        gpio_select3;
  logic [1:0]  dbg_state3;

  int errors = 0;
  int checks = 0;

  gpio_access_arbiter #(.SEL_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .gpio_addr(gpio_addr),
    .gpio_wdata(gpio_wdata), .gpio_select(gpio_select), .gpio_rdata(gpio_rdata),
    .dbg_state_o(dbg_state)
  );

  gpio_access_arbiter #(.SEL_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_ready(req_ready3),
    .req_rvalid(req_rvalid3), .req_rdata(req_rdata3), .gpio_addr(gpio_addr3),
    .gpio_wdata(gpio_wdata3), .gpio_select(gpio_select3), .gpio_rdata(gpio_rdata3),
    .dbg_state_o(dbg_state3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; gpio_rdata = '0;
    req_valid3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0; gpio_rdata3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (req_rvalid !== 2'b00 || req_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp: got rvalid=%b rdata=%h want 00/0", req_rvalid, req_rdata); end
    checks++; if (gpio_select !== 1'b0 || gpio_addr !== 32'h0 || gpio_wdata !== 32'h0) begin errors++; $display("FAIL reset_gpio: got sel=%b addr=%h wdata=%h want 0", gpio_select, gpio_addr, gpio_wdata); end
    checks++; if (dbg_state !== 2'd0 || dbg_state3 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d/%0d want 0/0", dbg_state, dbg_state3); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h1}; gpio_rdata = 32'hA5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_ready: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (gpio_select !== 1'b1 || gpio_addr !== 32'h1) begin errors++; $display("FAIL read_select: got sel=%b addr=%h want 1/1", gpio_select, gpio_addr); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL read_busy_ready: got %b want 00", req_ready); end
    @(negedge clk); #1;
    checks++; if (gpio_select !== 1'b0 || req_rvalid !== 2'b00) begin errors++; $display("FAIL read_capture: got sel=%b rvalid=%b want 0/00", gpio_select, req_rvalid); end
    @(negedge clk); #1;
    checks++; if (req_rvalid !== 2'b01 || req_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL read_resp: got rvalid=%b rdata=%h want 01/000000a5", req_rvalid, req_rdata); end
    @(negedge clk); #1;
    checks++; if (req_rvalid !== 2'b00 || req_rdata !== 32'h0) begin errors++; $display("FAIL read_resp_end: got rvalid=%b rdata=%h want 00/0", req_rvalid, req_rdata); end
  endtask

  task automatic test_write();
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b10; gpio_rdata = 32'hDEAD_BEEF;
    req_addr = {32'h0, 32'hFFFF_FFFF}; req_wdata = {32'h3C, 32'h1234_5678};
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL write_ready: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (gpio_select !== 1'b1 || gpio_addr !== 32'h0 || gpio_wdata !== 32'h3C) begin errors++; $display("FAIL write_select: got sel=%b addr=%h wdata=%h want 1/0/3c", gpio_select, gpio_addr, gpio_wdata); end
    @(negedge clk); #1;
    checks++; if (gpio_select !== 1'b0 || gpio_wdata !== 32'h3C) begin errors++; $display("FAIL write_hold: got sel=%b wdata=%h want 0/3c", gpio_select, gpio_wdata); end
    @(negedge clk); #1;
    checks++; if (req_rvalid !== 2'b10 || req_rdata !== 32'h0) begin errors++; $display("FAIL write_resp: got rvalid=%b rdata=%h want 10/0", req_rvalid, req_rdata); end
    @(negedge clk); req_we = 2'b00;
  endtask

  task automatic test_ties();
    int exp_idx [4];
    logic [1:0] exp_ready;
    int cyc;
`ifdef GPIO_ARB_ROUND_ROBIN_EN
    exp_idx = '{0, 1, 0, 1};
`else
    exp_idx = '{0, 0, 0, 0};
`endif
    @(negedge clk);
    req_valid = 2'b11; req_we = 2'b00; req_addr = {32'h1, 32'h1}; gpio_rdata = 32'h11;
    #1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (req_ready === 2'b00 && cyc < 10) begin
        @(negedge clk); #1; cyc++;
      end
      exp_ready = (exp_idx[k] == 1) ? 2'b10 : 2'b01;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL tie_grant%0d: got %b want %b", k, req_ready, exp_ready); end
      if (k > 0) begin
        checks++; if (cyc !== 3) begin errors++; $display("FAIL tie_spacing%0d: got %0d idle waits want 3", k, cyc); end
      end
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    // After the tie run the last grant was requester 1 (round-robin) or 0; a lone request wins regardless.
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h1, 32'h0}; gpio_rdata = 32'h77;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_rvalid !== 2'b10 || req_rdata !== 32'h77) begin errors++; $display("FAIL single_resp: got rvalid=%b rdata=%h want 10/77", req_rvalid, req_rdata); end
    @(negedge clk);
  endtask

  task automatic test_drop();
    int sel_seen;
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h1}; gpio_rdata = 32'h42;
    @(negedge clk); req_valid = 2'b10;
    @(negedge clk); req_valid = 2'b00; #1;
    @(negedge clk); #1;
    checks++; if (req_rvalid !== 2'b01 || req_rdata !== 32'h42) begin errors++; $display("FAIL drop_resp: got rvalid=%b rdata=%h want 01/42", req_rvalid, req_rdata); end
    sel_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (gpio_select === 1'b1 || req_rvalid !== 2'b00) sel_seen++;
    end
    checks++; if (sel_seen !== 0) begin errors++; $display("FAIL drop_no_txn: got %0d active cycles want 0", sel_seen); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL drop_idle: got state %0d want 0", dbg_state); end
  endtask

  task automatic test_sel3();
    logic [7:0] sel_mask;
    int rv_off;
    int rv_cnt;
    logic [31:0] rv_data;
    sel_mask = '0; rv_off = -1; rv_cnt = 0; rv_data = '0;
    @(negedge clk);
    req_valid3 = 2'b01; req_we3 = 2'b00; req_addr3 = {32'h0, 32'h1}; gpio_rdata3 = 32'h5A;
    #1;
    checks++; if (req_ready3 !== 2'b01) begin errors++; $display("FAIL sel3_ready: got %b want 01", req_ready3); end
    for (int off = 1; off < 8; off++) begin
      @(negedge clk);
      req_valid3 = 2'b00;
      #1;
      sel_mask[off] = gpio_select3;
      if (req_rvalid3 !== 2'b00) begin
        rv_cnt++; rv_off = off; rv_data = req_rdata3;
      end
    end
    checks++; if (sel_mask !== 8'b0000_1110) begin errors++; $display("FAIL sel3_select: got mask %b want 00001110", sel_mask); end
    checks++; if (rv_cnt !== 1 || rv_off !== 5) begin errors++; $display("FAIL sel3_latency: got %0d pulses at %0d want 1 at 5", rv_cnt, rv_off); end
    checks++; if (rv_data !== 32'h5A) begin errors++; $display("FAIL sel3_rdata: got %h want 5a", rv_data); end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    @(negedge clk);
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h9, 32'h0}; gpio_rdata = 32'h66;
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (gpio_select !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got sel=%b want 1", gpio_select); end
    rst = 1'b1; #1;
    checks++; if (gpio_select !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_drop: got sel=%b state=%0d want 0/0", gpio_select, dbg_state); end
    @(negedge clk); rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (req_rvalid !== 2'b00) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rstmid_no_rvalid: got %0d pulses want 0", rv_seen); end
    @(negedge clk);
    req_valid = 2'b11; req_addr = {32'h1, 32'h1}; gpio_rdata = 32'hC3;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant: got %b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++; if (gpio_select !== 1'b1) begin errors++; $display("FAIL rstmid_select: got %b want 1", gpio_select); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_rvalid !== 2'b01 || req_rdata !== 32'hC3) begin errors++; $display("FAIL rstmid_resp: got rvalid=%b rdata=%h want 01/c3", req_rvalid, req_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ties();
    test_single();
    test_drop();
    test_sel3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_access_arbiter.md
GPIO_ACCESS_ARBITER -- requirements
Module: gpio_access_arbiter

Interface
REQ-001 Parameter SEL_CYCLES, default 1, number of consecutive cycles gpio_select is held per transaction; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester transaction request; bit i belongs to requester i.
REQ-005 req_we  input  2  per-requester write enable; 1 = write, 0 = read.
REQ-006 req_addr  input  64  per-requester address; requester i uses bits [32*i+31:32*i].
REQ-007 req_wdata  input  64  per-requester write data; same packing as req_addr.
REQ-008 req_ready  output  2  request accepted this cycle; one-hot or zero.
REQ-009 req_rvalid  output  2  one-cycle completion pulse to the owning requester; one-hot or zero.
REQ-010 req_rdata  output  32  completion data, shared, valid while any req_rvalid bit is high.
REQ-011 gpio_addr  output  32  address to the GPIO port.
REQ-012 gpio_wdata  output  32  write data to the GPIO port.
REQ-013 gpio_select  output  1  GPIO port select strobe.
REQ-014 gpio_rdata  input  32  read data from the GPIO port.

Function
REQ-015 FSM states: IDLE, SELECT, CAPTURE, RESP; transitions IDLE->SELECT on accept, SELECT->CAPTURE after SEL_CYCLES cycles, CAPTURE->RESP and RESP->IDLE unconditionally.
REQ-016 In IDLE, grant is combinational from req_valid and the last-grant pointer; req_ready[i] = IDLE & grant[i].
REQ-017 Accept (req_valid[i] & req_ready[i]) latches addr, wdata, we and the owner index; the last-grant pointer updates to i.
REQ-018 gpio_select is 1 only in SELECT; gpio_addr and gpio_wdata drive the latched values and hold them in all states.
REQ-019 The SELECT dwell is counted by a 4-bit counter loaded with SEL_CYCLES-1 on accept.
REQ-020 At the rising edge ending CAPTURE, gpio_rdata is registered for reads; for writes the register loads 32'h0.
REQ-021 In RESP, req_rvalid[owner]=1 and req_rdata = registered value; otherwise req_rvalid=0 and req_rdata=0.
REQ-022 Latency: accept in cycle N; select in cycles N+1..N+SEL_CYCLES; rvalid in cycle N+SEL_CYCLES+2.
REQ-023 No accept outside IDLE; the next accept is earliest in the cycle after RESP.
REQ-024 A requester may drop req_valid before ready; no transaction results and the pointer is unchanged.
REQ-025 A single valid requester is always granted in IDLE, regardless of the pointer.

Reset
REQ-026 On rst: state=IDLE, pointer=1 (requester 0 wins first tie), counter=0, latched addr/wdata/rdata=0, all outputs 0.
REQ-027 Reset mid-transaction drops gpio_select immediately and suppresses the pending rvalid.

Configuration
REQ-028 With GPIO_ARB_ROUND_ROBIN_EN defined, simultaneous requests are granted to the requester not granted last.
REQ-029 Without GPIO_ARB_ROUND_ROBIN_EN, requester 0 always wins ties and the pointer is unused.

Structure
REQ-030 The FSM state encoding, the requester count (2) and the GPIO register offsets (OUT=2'h0, IN=2'h1) belong in a shared package gpio_arb_pkg.
REQ-031 The grant logic is a separate sub-module, gpio_arb_grant (req_valid, pointer -> grant).

Verification
REQ-032 Read by requester 0, addr 0x1, gpio_rdata=0xA5, SEL_CYCLES=1 -> ready at N, select at N+1, rvalid[0] with rdata=0x000000A5 at N+3.
REQ-033 Write by requester 1, addr 0x0, wdata 0x3C -> gpio_select one cycle with gpio_addr=0x0, gpio_wdata=0x3C; rvalid[1] with rdata=0.
REQ-034 Both requesters hold valid for four transactions with the macro defined -> grants 0,1,0,1; without the macro -> 0,0,0,0.
REQ-035 SEL_CYCLES=3 read -> gpio_select high exactly 3 cycles; rvalid at N+5.
REQ-036 rst asserted during SELECT -> gpio_select=0 the same cycle; no rvalid; the next request after release is granted to requester 0 with full latency.
